fetch_stage_unit: RTL
=====================

Name: fetch_stage_unit

Overview:
IF stage of the 5-stage RV32 pipeline, directly upstream of the ID-stage control unit and its NOP mux. Contents:
- PC register and PC+4 increment.
- Instruction-memory (ROM) address drive.
- IF/ID pipeline register.
- Small control FSM for boot, stall, and branch/jump redirect.

On a redirect it squashes both wrong-path instructions: the one in IF by loading a NOP into IF/ID, and the one in ID by asserting the control-unit NOP select.

Parameters:
ADDR_W, 9, instruction ROM byte-address width; imem_addr = pc[ADDR_W-1:0].
RESET_PC, 32'h0000_0000, PC value on reset.
NOP_INSTR, 32'h0000_0000, bubble word; the control unit decodes it as all-zero control.

Ports:
clk  in  1  pipeline clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high.
pc_le  in  1  PC/IF-ID load enable from hazard unit; 0 = stall.
redirect  in  1  taken branch/JAL/JALR resolved in EX.
tgt_addr  in  32  redirect target from EX.
imem_data  in  32  instruction word returned by ROM (combinational read).
imem_addr  out  ADDR_W  ROM address.
pc_out  out  32  current PC.
id_instruction  out  32  IF/ID instruction.
id_pc  out  32  IF/ID PC.
id_valid  out  1  IF/ID holds a real instruction.
id_squash  out  1  drives control-unit NOP mux select (s).
fsm_state  out  2  BOOT=00, RUN=01, STALL=10, FLUSH=11 (debug).

Behaviour:
- Reset (asynchronous, any time including mid-operation) forces:
  - pc_out=RESET_PC
  - id_instruction=NOP_INSTR, id_pc=0, id_valid=0
  - id_squash=0
  - fsm_state=BOOT
- imem_addr = pc_out[ADDR_W-1:0]; combinational, no latency.
- id_squash = redirect. Combinational, asserted in the same cycle as redirect; it squashes the instruction currently in ID. It is never asserted in BOOT.
- BOOT: occupies the first clock edge after reset deassertion.
  - PC holds; IF/ID holds NOP with valid=0.
  - Next state is RUN. Inputs are ignored.
  - Result: the instruction at RESET_PC reaches ID on the 2nd edge after release.
- RUN, STALL, FLUSH all evaluate the same rules each edge, in priority order:
  1. redirect=1 (wins over pc_le=0):
     - pc <= {tgt_addr[31:2],2'b00} (alignment forced).
     - IF/ID <= {NOP_INSTR, id_pc=0, valid=0}.
     - state <= FLUSH.
  2. pc_le=0:
     - pc, id_instruction, id_pc, id_valid all hold.
     - state <= STALL.
  3. Otherwise:
     - pc <= pc+4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
     - id_instruction <= imem_data, id_pc <= pc, id_valid <= 1.
     - state <= RUN.
- FLUSH lasts exactly one cycle unless redirect is re-asserted; back-to-back redirects stay in FLUSH.
- A stall arriving during FLUSH holds the bubble (valid stays 0).
- Latency: PC to ID is 1 cycle; redirect to target in ID is 2 cycles.
- No X propagation: imem_data is sampled only under rule 3.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on every rule-3 edge.
  - stall_count increments on every rule-2 edge.
  - Both wrap at 2^32.
  - BOOT and redirect edges count in neither.
- Undefined: the ports still exist but are tied to 32'h0; no counter flops are synthesized.

Test Plan:
1. Reset at t=0, release before edge 1, pc_le=1, ROM[0..7]=ADDI, SUB: edge 1 gives state RUN, pc=0, valid=0. Edge 2 gives id_instruction=ROM word@0, id_pc=0, pc=4, valid=1. Edge 3 gives id_pc=4, pc=8.
2. At pc=12, hold pc_le=0 for 3 edges: pc stays 12, IF/ID unchanged, fsm_state=10. On release, next edge gives pc=16, id_pc=12. FETCH_PERF_CNT_EN: stall_count=3.
3. At pc=20, redirect=1, tgt_addr=0x42, pc_le=0 in the same cycle: id_squash=1 combinationally. Edge gives pc=0x40, id_instruction=0, valid=0, state=FLUSH. Next edge gives id_pc=0x40, valid=1, state=RUN.
4. Redirect on two consecutive edges (tgt 0x80 then 0x100): state stays FLUSH. pc ends at 0x100, valid=0. The following edge loads id_pc=0x100.
5. Force pc=0xFFFF_FFFC via redirect, then run: pc wraps to 0x0000_0000 and imem_addr=0.
6. Assert reset mid-stream between edges with pc=0x24: pc_out=0 and valid=0 immediately, before the next edge. After release, BOOT repeats the scenario-1 sequence.

Source files
------------

// File: rtl/fetch_stage_unit_if.sv
// Bundle of the IF-stage handshake, ROM and IF/ID signals between fetch_stage_unit and its neighbours.
// fetch_count/stall_count are always present; they read zero unless FETCH_PERF_CNT_EN is defined.
interface fetch_stage_unit_if #(
    parameter int ADDR_W = 9
);
    logic              pc_le;
    logic              redirect;
    logic [31:0]       tgt_addr;
    logic [31:0]       imem_data;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       pc_out;
    logic [31:0]       id_instruction;
    logic [31:0]       id_pc;
    logic              id_valid;
    logic              id_squash;
    logic [1:0]        fsm_state;
    logic [31:0]       fetch_count;
    logic [31:0]       stall_count;

    modport master (
        input  pc_le, redirect, tgt_addr, imem_data,
        output imem_addr, pc_out, id_instruction, id_pc, id_valid,
               id_squash, fsm_state, fetch_count, stall_count
    );

    modport slave (
        output pc_le, redirect, tgt_addr, imem_data,
        input  imem_addr, pc_out, id_instruction, id_pc, id_valid,
               id_squash, fsm_state, fetch_count, stall_count
    );
endinterface

// File: rtl/fetch_stage_unit.sv
// RV32 IF stage: PC register, ROM address drive, IF/ID register and boot/stall/redirect FSM.
// Optional FETCH_PERF_CNT_EN adds fetch/stall event counters.
module fetch_stage_unit #(
    parameter int          ADDR_W    = 9,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_stage_unit_if.master    bus
);
    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_FLUSH = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] idpc_q, idpc_d;
    logic        valid_q, valid_d;

    // Redirect beats stall; imem_data is only consumed on a normal advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        idpc_d  = idpc_q;
        valid_d = valid_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (bus.redirect) begin
                    pc_d    = bus.tgt_addr & 32'hFFFF_FFFC;
                    instr_d = NOP_INSTR;
                    idpc_d  = 32'h0000_0000;
                    valid_d = 1'b0;
                    state_d = ST_FLUSH;
                end else if (!bus.pc_le) begin
                    state_d = ST_STALL;
                end else begin
                    pc_d    = pc_q + 32'd4;
                    instr_d = bus.imem_data;
                    idpc_d  = pc_q;
                    valid_d = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            idpc_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            idpc_q  <= idpc_d;
            valid_q <= valid_d;
        end
    end

    assign bus.imem_addr      = pc_q[ADDR_W-1:0];
    assign bus.pc_out         = pc_q;
    assign bus.id_instruction = instr_q;
    assign bus.id_pc          = idpc_q;
    assign bus.id_valid       = valid_q;
    assign bus.fsm_state      = state_q;
    // BOOT has nothing in ID yet, so there is nothing to squash.
    assign bus.id_squash      = bus.redirect & (state_q != ST_BOOT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Count advance and stall edges; BOOT and redirect edges are excluded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'h0000_0000;
            stall_cnt_q <= 32'h0000_0000;
        end else if ((state_q != ST_BOOT) && !bus.redirect) begin
            if (bus.pc_le) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign bus.fetch_count = fetch_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.fetch_count = 32'h0000_0000;
    assign bus.stall_count = 32'h0000_0000;
`endif
endmodule
